caliptra_fdm_fuse_writer: RTL and testbench
===========================================

# caliptra_fdm_fuse_writer

Sequencer that sits directly downstream of the FDM fuse look-up table fetch stage. It walks the table entry by entry, issuing a registered read and decoding each `{mask, value, address}` element. It then writes `value & mask` into the SoC interface register file through an APB master port. It stops on the end-of-table marker, an APB error, or (optionally) a readback mismatch.

## Interface
Parameters:
- `LUT_ENTRIES`, 64: number of table entries, including the EOF entry.
- `IW`, `$clog2(LUT_ENTRIES)`: index width.

Ports:
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset. Asynchronous assertion, active-low.
- `i_start` in 1: start a pass. Sampled only in IDLE, DONE or ERR.
- `o_busy` out 1: high from the cycle after `i_start` until DONE or ERR is entered.
- `o_done` out 1: level. High while in DONE.
- `o_error` out 1: level. High while in ERR.
- `o_err_code` out 2: 0 = none, 1 = APB slave error, 2 = table exhausted without EOF, 3 = readback mismatch.
- `o_err_idx` out IW: table index of the failing entry.
- `o_lut_readen` out 1: read enable to the fetch stage.
- `o_lut_raddr` out IW: read index.
- `i_lut_rdata` in 96: element. Bits [95:64] are mask, [63:32] are value, [31:0] are address. Valid the cycle after `o_lut_readen`.
- `o_psel`, `o_penable`, `o_pwrite` out 1 each: APB control.
- `o_paddr` out 32: APB address.
- `o_pwdata` out 32: APB write data.
- `i_pready` in 1, `i_prdata` in 32, `i_pslverr` in 1: APB response.

## Operation
Registers: `idx_q` (IW bits) and `entry_q` (96 bits).

States and transitions:
- **IDLE/DONE/ERR**: on `i_start`, clear `idx_q` and `o_err_code`, then go to FETCH.
- **FETCH**: drive `o_lut_readen=1` and `o_lut_raddr=idx_q`, then go to LATCH.
- **LATCH**: capture `i_lut_rdata` into `entry_q`, then decide on the raw `i_lut_rdata`:
  - Address == 32'hFFFF_FFFF: go to DONE.
  - Otherwise, mask == 0 (entry skipped, no bus access):
    - If `idx_q == LUT_ENTRIES-1`: go to ERR with code 2.
    - Else increment `idx_q` and go to FETCH.
  - Otherwise: go to SETUP.
- **SETUP**: `o_psel=1`, `o_penable=0`, `o_pwrite=1`, `o_paddr=entry_q.addr`, `o_pwdata=value & mask`. Go to ACCESS.
- **ACCESS**: same signals with `o_penable=1`. Hold until `i_pready`. Then:
  - `i_pslverr` set: go to ERR with code 1.
  - Else, if `idx_q == LUT_ENTRIES-1`: go to ERR with code 2.
  - Else increment `idx_q` and go to FETCH (or RB_SETUP when readback is enabled).

Error handling:
- `o_err_idx` is loaded with `idx_q` on every ERR entry.
- APB signals are held stable throughout ACCESS wait states.
- `o_pwdata` is 0 whenever `o_psel` is 0.

Unused states:
- `i_start` during FETCH through ACCESS is ignored.
- Unreachable state encodings return to IDLE.

## Timing
- All outputs are registered, and all of them are 0 in reset.
- Reset asserted mid-transfer: drops `o_psel` and `o_penable` immediately and returns to IDLE. No retry.
- Cycles per written entry, zero-wait APB: 4 (FETCH, LATCH, SETUP, ACCESS). Each APB wait state adds 1.
- Cycles per skipped (mask == 0) entry: 2.
- EOF: the EOF entry at index k reaches DONE k_written·4 + k_skipped·2 + 2 cycles after `i_start` is sampled.
- `o_busy` deasserts in the same cycle `o_done` or `o_error` rises.
- Simultaneous `i_pready` and `i_pslverr`: the error takes priority and the index is not advanced.

## Configuration
- `CALIPTRA_FDM_READBACK_EN` defined: two states are added after each successful write.
  - RB_SETUP: `o_pwrite=0`, same address.
  - RB_ACCESS: wait for `i_pready`. Then:
    - `i_pslverr`: ERR with code 1.
    - `(i_prdata & mask) != (value & mask)`: ERR with code 3.
    - Otherwise advance exactly as after a write.
  - Per-entry cost becomes 6 cycles.
- `CALIPTRA_FDM_READBACK_EN` undefined: no read transactions are ever issued, and code 3 is unreachable.

## Test plan
- **Normal pass.** Table of 3 entries + EOF: `{FFFF_FFFF, 1234_5678, 0x200}`, `{0000_FFFF, ABCD_EF01, 0x204}`, `{0, x, 0x208}`, EOF. Start, zero-wait slave. Required:
  - Writes (0x200, 1234_5678) then (0x204, 0000_EF01).
  - No access to 0x208.
  - `o_done` rises 12 cycles after start.
- **Wait states.** Slave inserts 3 wait states on the first write. Required: APB signals held stable, `o_done` is 3 cycles later than in the normal pass.
- **Slave error.** `i_pslverr` on the second write. Required: `o_error=1`, `o_err_code=1`, `o_err_idx=1`, no further LUT reads.
- **Missing EOF.** `LUT_ENTRIES=4` with no EOF entry. Required: after index 3, `o_err_code=2` and `o_err_idx=3`.
- **Reset mid-transfer.** Assert `i_rst_n=0` during ACCESS. Required: all outputs 0 in the same cycle. After release, a new start rewrites from index 0.
- **Readback (`CALIPTRA_FDM_READBACK_EN` defined).** Slave returns 1234_5679 for 0x200 with mask FFFF_FFFF. Required: `o_err_code=3`, `o_err_idx=0`.

Source files
------------

// File: rtl/caliptra_fdm_fuse_writer.sv
// caliptra_fdm_fuse_writer
// Walks the FDM fuse look-up table one entry at a time. Each entry is a
// {mask, value, address} element. For each entry it writes (value & mask)
// to the SoC register file over an APB master port.
// The walk stops on the end-of-table address marker, on an APB slave error,
// or when the last index is passed without finding the marker.
// Optional feature macro: CALIPTRA_FDM_READBACK_EN. When it is defined, each
// write is followed by an APB read of the same address. The masked read data
// must match the masked value that was written.
// All outputs are registered and are cleared by the asynchronous reset.
module caliptra_fdm_fuse_writer #(
  parameter int LUT_ENTRIES = 64,
  parameter int IW          = $clog2(LUT_ENTRIES)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error,
  output logic [1:0]    o_err_code,
  output logic [IW-1:0] o_err_idx,
  output logic          o_lut_readen,
  output logic [IW-1:0] o_lut_raddr,
  input  logic [95:0]   i_lut_rdata,
  output logic          o_psel,
  output logic          o_penable,
  output logic          o_pwrite,
  output logic [31:0]   o_paddr,
  output logic [31:0]   o_pwdata,
  input  logic          i_pready,
  input  logic [31:0]   i_prdata,
  input  logic          i_pslverr
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_LATCH     = 4'd2,
    S_SETUP     = 4'd3,
    S_ACCESS    = 4'd4,
    S_RB_SETUP  = 4'd5,
    S_RB_ACCESS = 4'd6,
    S_DONE      = 4'd7,
    S_ERR       = 4'd8
  } state_e;

  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] value;
    logic [31:0] addr;
  } entry_t;

  localparam logic [1:0]    ERR_NONE     = 2'd0;
  localparam logic [1:0]    ERR_SLAVE    = 2'd1;
  localparam logic [1:0]    ERR_NO_EOF   = 2'd2;
`ifdef CALIPTRA_FDM_READBACK_EN
  localparam logic [1:0]    ERR_READBACK = 2'd3;
`endif
  localparam logic [31:0]   EOF_ADDR     = 32'hFFFF_FFFF;
  localparam logic [IW-1:0] LAST_IDX     = IW'(LUT_ENTRIES - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  entry_t        entry_q, entry_d;
  logic [1:0]    err_code_d;
  logic [IW-1:0] err_idx_d;
  logic          at_last;

  logic          busy_d, done_d, error_d, readen_d;
  logic [IW-1:0] raddr_d;
  logic          psel_d, penable_d, pwrite_d;
  logic [31:0]   paddr_d, pwdata_d;

`ifndef CALIPTRA_FDM_READBACK_EN
  // Read data is only consumed by the readback check.
  logic unused_prdata;
  assign unused_prdata = ^i_prdata;
`endif

  // While in LATCH, decisions and the SETUP outputs use the raw table data.
  // In every other state they use the captured copy.
  assign entry_d = (state_q == S_LATCH) ? entry_t'(i_lut_rdata) : entry_q;
  assign at_last = (idx_q == LAST_IDX);

  // State, index, entry and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      // NOTE: the entry register is cleared too. The APB address and data
      // outputs are built from it, so they start from a known zero.
      entry_q      <= '0;
      o_err_code   <= ERR_NONE;
      o_err_idx    <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_lut_readen <= 1'b0;
      o_lut_raddr  <= '0;
      o_psel       <= 1'b0;
      o_penable    <= 1'b0;
      o_pwrite     <= 1'b0;
      o_paddr      <= '0;
      o_pwdata     <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register see the values
      // from before this edge, so the order of statements does not matter.
      state_q      <= state_d;
      idx_q        <= idx_d;
      entry_q      <= entry_d;
      o_err_code   <= err_code_d;
      o_err_idx    <= err_idx_d;
      o_busy       <= busy_d;
      o_done       <= done_d;
      o_error      <= error_d;
      o_lut_readen <= readen_d;
      o_lut_raddr  <= raddr_d;
      o_psel       <= psel_d;
      o_penable    <= penable_d;
      o_pwrite     <= pwrite_d;
      o_paddr      <= paddr_d;
      o_pwdata     <= pwdata_d;
    end
  end

  // Next-state, index and error bookkeeping
  always_comb begin
    // NOTE: every output of this block gets a hold value first. That way no
    // path leaves a signal unassigned, and no latch is inferred.
    state_d    = state_q;
    idx_d      = idx_q;
    err_code_d = o_err_code;
    err_idx_d  = o_err_idx;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_start) begin
          state_d    = S_FETCH;
          idx_d      = '0;
          err_code_d = ERR_NONE;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        if (entry_d.addr == EOF_ADDR) begin
          state_d = S_DONE;
        end else if (entry_d.mask == '0) begin
          if (at_last) begin
            state_d    = S_ERR;
            err_code_d = ERR_NO_EOF;
            err_idx_d  = idx_q;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_SETUP;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (i_pready) begin
          if (i_pslverr) begin
            state_d    = S_ERR;
            err_code_d = ERR_SLAVE;
            err_idx_d  = idx_q;
`ifdef CALIPTRA_FDM_READBACK_EN
          end else begin
            state_d = S_RB_SETUP;
          end
`else
          end else if (at_last) begin
            state_d    = S_ERR;
            err_code_d = ERR_NO_EOF;
            err_idx_d  = idx_q;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_FETCH;
          end
`endif
        end
      end
`ifdef CALIPTRA_FDM_READBACK_EN
      S_RB_SETUP: state_d = S_RB_ACCESS;
      S_RB_ACCESS: begin
        if (i_pready) begin
          if (i_pslverr) begin
            state_d    = S_ERR;
            err_code_d = ERR_SLAVE;
            err_idx_d  = idx_q;
          end else if ((i_prdata & entry_q.mask) != (entry_q.value & entry_q.mask)) begin
            state_d    = S_ERR;
            err_code_d = ERR_READBACK;
            err_idx_d  = idx_q;
          end else if (at_last) begin
            state_d    = S_ERR;
            err_code_d = ERR_NO_EOF;
            err_idx_d  = idx_q;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_FETCH;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the state being entered; registered on the next edge
  always_comb begin
    busy_d    = !(state_d inside {S_IDLE, S_DONE, S_ERR});
    done_d    = (state_d == S_DONE);
    error_d   = (state_d == S_ERR);
    readen_d  = 1'b0;
    raddr_d   = '0;
    psel_d    = 1'b0;
    penable_d = 1'b0;
    pwrite_d  = 1'b0;
    paddr_d   = '0;
    pwdata_d  = '0;
    case (state_d)
      S_FETCH: begin
        readen_d = 1'b1;
        raddr_d  = idx_d;
      end
      S_SETUP, S_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = (state_d == S_ACCESS);
        pwrite_d  = 1'b1;
        paddr_d   = entry_d.addr;
        pwdata_d  = entry_d.value & entry_d.mask;
      end
`ifdef CALIPTRA_FDM_READBACK_EN
      S_RB_SETUP, S_RB_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = (state_d == S_RB_ACCESS);
        paddr_d   = entry_d.addr;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_caliptra_fdm_fuse_writer.sv
// Testbench for caliptra_fdm_fuse_writer.
// The design is built with a 4-entry table. A registered LUT model and an
// APB slave model drive it; the slave has programmable wait states, error
// address and readback corruption.
// Expected APB transfers go into a scoreboard queue when each test is set
// up. Completed transfers are collected by the slave and compared at the
// end of each test.
module tb_caliptra_fdm_fuse_writer;

  localparam int N  = 4;
  localparam int IW = $clog2(N);
`ifdef CALIPTRA_FDM_READBACK_EN
  localparam int WR = 6;
  localparam bit RB = 1'b1;
`else
  localparam int WR = 4;
  localparam bit RB = 1'b0;
`endif
  localparam int NORMAL_CYC = 2 * WR + 2 + 2;
  localparam logic [95:0] EOF_E = {32'h0, 32'h0, 32'hFFFF_FFFF};
  localparam logic [31:0] NO_ADDR = 32'hDEAD_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
  } xfer_t;

  logic          i_clk, i_rst_n, i_start;
  logic          o_busy, o_done, o_error;
  logic [1:0]    o_err_code;
  logic [IW-1:0] o_err_idx;
  logic          o_lut_readen;
  logic [IW-1:0] o_lut_raddr;
  logic [95:0]   i_lut_rdata = '0;
  logic          o_psel, o_penable, o_pwrite;
  logic [31:0]   o_paddr, o_pwdata;
  logic          i_pready = 1'b0;
  logic [31:0]   i_prdata = '0;
  logic          i_pslverr = 1'b0;

  int checks = 0;
  int passes = 0;

  xfer_t       exp_q[$];
  xfer_t       obs_q[$];
  logic [95:0] lut [N];
  int          first_waits = 0;
  logic [31:0] err_addr    = NO_ADDR;
  logic [31:0] bad_rb_addr = NO_ADDR;
  int          lut_reads   = 0;
  int          txn_cnt     = 0;
  int          wait_cnt    = 0;
  logic [64:0] snap        = '0;
  bit          unstable    = 1'b0;
  bit          leak        = 1'b0;
  logic [31:0] last_wdata  = '0;

  caliptra_fdm_fuse_writer #(.LUT_ENTRIES(N)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_err_code   (o_err_code),
    .o_err_idx    (o_err_idx),
    .o_lut_readen (o_lut_readen),
    .o_lut_raddr  (o_lut_raddr),
    .i_lut_rdata  (i_lut_rdata),
    .o_psel       (o_psel),
    .o_penable    (o_penable),
    .o_pwrite     (o_pwrite),
    .o_paddr      (o_paddr),
    .o_pwdata     (o_pwdata),
    .i_pready     (i_pready),
    .i_prdata     (i_prdata),
    .i_pslverr    (i_pslverr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Registered table read: data valid the cycle after the read enable
  always @(posedge i_clk) begin
    if (i_start) lut_reads <= 0;
    if (o_lut_readen) begin
      i_lut_rdata <= lut[o_lut_raddr];
      lut_reads   <= lut_reads + 1;
    end
  end

  // APB slave: wait states on the first transfer of a pass, error on one
  // write address, read data = last written data, optionally corrupted
  always @(posedge i_clk) begin
    if (i_start) begin
      txn_cnt  <= 0;
      unstable <= 1'b0;
      leak     <= 1'b0;
    end
    if (!o_psel && o_pwdata != 32'h0) leak <= 1'b1;
    if (o_psel && !o_penable) begin
      snap      <= {o_paddr, o_pwdata, o_pwrite};
      wait_cnt  <= 0;
      i_pready  <= ((txn_cnt == 0 ? first_waits : 0) == 0);
      i_pslverr <= o_pwrite && (o_paddr == err_addr);
      i_prdata  <= last_wdata ^ ((o_paddr == bad_rb_addr) ? 32'h1 : 32'h0);
    end else if (o_psel && o_penable && !i_pready) begin
      if ({o_paddr, o_pwdata, o_pwrite} != snap) unstable <= 1'b1;
      wait_cnt  <= wait_cnt + 1;
      i_pready  <= (wait_cnt + 1 >= (txn_cnt == 0 ? first_waits : 0));
      i_pslverr <= o_pwrite && (o_paddr == err_addr);
    end else if (o_psel && o_penable && i_pready) begin
      obs_q.push_back({o_paddr, (o_pwrite ? o_pwdata : 32'h0), o_pwrite});
      if (o_pwrite) last_wdata <= o_pwdata;
      txn_cnt   <= txn_cnt + 1;
      i_pready  <= 1'b0;
      i_pslverr <= 1'b0;
    end else begin
      i_pready  <= 1'b0;
      i_pslverr <= 1'b0;
    end
  end

  function automatic logic [95:0] ent(input logic [31:0] m, input logic [31:0] v,
                                      input logic [31:0] a);
    return {m, v, a};
  endfunction

  task automatic load_table(input logic [95:0] e0, input logic [95:0] e1,
                            input logic [95:0] e2, input logic [95:0] e3);
    lut[0] = e0;
    lut[1] = e1;
    lut[2] = e2;
    lut[3] = e3;
  endtask

  task automatic load_normal();
    load_table(ent(32'hFFFF_FFFF, 32'h1234_5678, 32'h200),
               ent(32'h0000_FFFF, 32'hABCD_EF01, 32'h204),
               ent(32'h0, 32'h5555_AAAA, 32'h208), EOF_E);
  endtask

  // Expected write plus, with readback built in, the read that follows it
  task automatic push_entry(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d, 1'b1});
    if (RB) exp_q.push_back({a, 32'h0, 1'b0});
  endtask

  task automatic push_normal();
    push_entry(32'h200, 32'h1234_5678);
    push_entry(32'h204, 32'h0000_EF01);
  endtask

  // Pulse start; n = edges from the start-sampling edge to DONE/ERR (bounded)
  task automatic run_pass(output int n);
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    n = 0;
    while (!(o_done || o_error) && n < 200) begin
      @(negedge i_clk);
      n++;
    end
  endtask

  task automatic drain(input string name);
    xfer_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        $display("FAIL %s_xfer: got no transfer, want addr=%h data=%h wr=%b", name, e.addr, e.data, e.wr);
      end else begin
        o = obs_q.pop_front();
        if (o !== e)
          $display("FAIL %s_xfer: got addr=%h data=%h wr=%b, want addr=%h data=%h wr=%b",
                   name, o.addr, o.data, o.wr, e.addr, e.data, e.wr);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) $display("FAIL %s_extra: got %0d extra transfers, want 0", name, obs_q.size());
    else passes++;
    obs_q.delete();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_start = 1'b0;
    #12;
    checks++;
    if ({o_busy, o_done, o_error, o_err_code, o_err_idx, o_lut_readen, o_lut_raddr,
         o_psel, o_penable, o_pwrite, o_paddr, o_pwdata} !== '0)
      $display("FAIL reset_outputs: got nonzero outputs, want all 0");
    else passes++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_normal();
    int n;
    load_normal();
    push_normal();
    run_pass(n);
    checks++; if (n !== NORMAL_CYC) $display("FAIL normal_cycles: got %0d want %0d", n, NORMAL_CYC); else passes++;
    checks++; if (o_done !== 1'b1) $display("FAIL normal_done: got %b want 1", o_done); else passes++;
    checks++; if (o_busy !== 1'b0) $display("FAIL normal_busy: got %b want 0", o_busy); else passes++;
    checks++; if (o_error !== 1'b0) $display("FAIL normal_error: got %b want 0", o_error); else passes++;
    checks++; if (o_err_code !== 2'd0) $display("FAIL normal_code: got %0d want 0", o_err_code); else passes++;
    checks++; if (leak !== 1'b0) $display("FAIL normal_pwdata_idle: got nonzero pwdata without psel, want 0"); else passes++;
    drain("normal");
  endtask

  task automatic test_wait_states();
    int n;
    first_waits = 3;
    load_normal();
    push_normal();
    run_pass(n);
    checks++; if (n !== NORMAL_CYC + 3) $display("FAIL wait_cycles: got %0d want %0d", n, NORMAL_CYC + 3); else passes++;
    checks++; if (unstable !== 1'b0) $display("FAIL wait_stable: got APB change during wait, want stable"); else passes++;
    checks++; if (o_done !== 1'b1) $display("FAIL wait_done: got %b want 1", o_done); else passes++;
    drain("wait");
    first_waits = 0;
  endtask

  task automatic test_slave_error();
    int n;
    err_addr = 32'h204;
    load_normal();
    push_entry(32'h200, 32'h1234_5678);
    exp_q.push_back({32'h204, 32'h0000_EF01, 1'b1});
    run_pass(n);
    repeat (5) @(negedge i_clk);
    checks++; if (o_error !== 1'b1) $display("FAIL slverr_error: got %b want 1", o_error); else passes++;
    checks++; if (o_err_code !== 2'd1) $display("FAIL slverr_code: got %0d want 1", o_err_code); else passes++;
    checks++; if (o_err_idx !== IW'(1)) $display("FAIL slverr_idx: got %0d want 1", o_err_idx); else passes++;
    checks++; if (lut_reads !== 2) $display("FAIL slverr_lut_reads: got %0d want 2", lut_reads); else passes++;
    checks++; if (o_done !== 1'b0) $display("FAIL slverr_done: got %b want 0", o_done); else passes++;
    drain("slverr");
    err_addr = NO_ADDR;
  endtask

  task automatic test_restart_from_err();
    int n;
    load_normal();
    push_normal();
    run_pass(n);
    checks++; if (n !== NORMAL_CYC) $display("FAIL restart_cycles: got %0d want %0d", n, NORMAL_CYC); else passes++;
    checks++; if (o_err_code !== 2'd0) $display("FAIL restart_code: got %0d want 0", o_err_code); else passes++;
    checks++; if (o_error !== 1'b0) $display("FAIL restart_error: got %b want 0", o_error); else passes++;
    drain("restart");
  endtask

  task automatic test_missing_eof();
    int n;
    load_table(ent(32'hFFFF_FFFF, 32'h0000_0001, 32'h300),
               ent(32'h0, 32'h0000_0002, 32'h304),
               ent(32'h0000_00FF, 32'h0000_1234, 32'h308),
               ent(32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h30C));
    push_entry(32'h300, 32'h0000_0001);
    push_entry(32'h308, 32'h0000_0034);
    push_entry(32'h30C, 32'hF0F0_F0F0);
    run_pass(n);
    checks++; if (n !== 3 * WR + 2) $display("FAIL noeof_cycles: got %0d want %0d", n, 3 * WR + 2); else passes++;
    checks++; if (o_err_code !== 2'd2) $display("FAIL noeof_code: got %0d want 2", o_err_code); else passes++;
    checks++; if (o_err_idx !== IW'(3)) $display("FAIL noeof_idx: got %0d want 3", o_err_idx); else passes++;
    drain("noeof");
    // Last entry skipped rather than written
    load_table(ent(32'h0, 32'h1, 32'h400), ent(32'h0, 32'h2, 32'h404),
               ent(32'h0, 32'h3, 32'h408), ent(32'h0, 32'h4, 32'h40C));
    run_pass(n);
    checks++; if (n !== 8) $display("FAIL noeof_skip_cycles: got %0d want 8", n); else passes++;
    checks++; if (o_err_code !== 2'd2) $display("FAIL noeof_skip_code: got %0d want 2", o_err_code); else passes++;
    checks++; if (o_err_idx !== IW'(3)) $display("FAIL noeof_skip_idx: got %0d want 3", o_err_idx); else passes++;
    drain("noeof_skip");
  endtask

  task automatic test_reset_mid();
    int n;
    int guard;
    first_waits = 3;
    load_normal();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    guard = 0;
    while (!o_penable && guard < 50) begin
      @(negedge i_clk);
      guard++;
    end
    checks++; if (o_busy !== 1'b1 || o_penable !== 1'b1) $display("FAIL rstmid_in_access: got busy=%b penable=%b want 1/1", o_busy, o_penable); else passes++;
    #1 i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_done, o_error, o_err_code, o_err_idx, o_lut_readen, o_lut_raddr,
         o_psel, o_penable, o_pwrite, o_paddr, o_pwdata} !== '0)
      $display("FAIL rstmid_outputs: got psel=%b penable=%b busy=%b, want all outputs 0", o_psel, o_penable, o_busy);
    else passes++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    first_waits = 0;
    obs_q.delete();
    push_normal();
    run_pass(n);
    checks++; if (n !== NORMAL_CYC) $display("FAIL rstmid_cycles: got %0d want %0d", n, NORMAL_CYC); else passes++;
    checks++; if (o_done !== 1'b1) $display("FAIL rstmid_done: got %b want 1", o_done); else passes++;
    drain("rstmid");
  endtask

`ifdef CALIPTRA_FDM_READBACK_EN
  task automatic test_readback();
    int n;
    bad_rb_addr = 32'h200;
    load_table(ent(32'hFFFF_FFFF, 32'h1234_5678, 32'h200), EOF_E, EOF_E, EOF_E);
    exp_q.push_back({32'h200, 32'h1234_5678, 1'b1});
    exp_q.push_back({32'h200, 32'h0, 1'b0});
    run_pass(n);
    checks++; if (o_error !== 1'b1) $display("FAIL rb_error: got %b want 1", o_error); else passes++;
    checks++; if (o_err_code !== 2'd3) $display("FAIL rb_code: got %0d want 3", o_err_code); else passes++;
    checks++; if (o_err_idx !== IW'(0)) $display("FAIL rb_idx: got %0d want 0", o_err_idx); else passes++;
    drain("rb");
    bad_rb_addr = NO_ADDR;
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_wait_states();
    test_slave_error();
    test_restart_from_err();
    test_missing_eof();
    test_reset_mid();
`ifdef CALIPTRA_FDM_READBACK_EN
    test_readback();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
